deadlock_report_sequencer: RTL and testbench

- Simulation-only stage directly downstream of the per-process deadlock detect units in the dataflow deadlock-detection harness.
- Collects their raw `dl_in_vec` flags and confirms a deadlock is persistent, not transient.
- Picks one origin process, freezes the detectors, records the dependency path the token walks, and presents a report record.
- On acknowledge, clears tokens and re-arms.

---
 rtl/deadlock_report_sequencer_if.sv | 34 +++
 rtl/deadlock_report_sequencer.sv | 173 +++++++++++++++++
 tb/tb_deadlock_report_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/deadlock_report_sequencer_if.sv
// Interface bundling the detect-unit flags, path hops and the report handshake
// for the deadlock report sequencer.
interface deadlock_report_sequencer_if #(
    parameter int unsigned PROC_NUM = 3,
    parameter int unsigned ID_WIDTH = 2,
    parameter int unsigned MAX_PATH = 8
);
    logic [PROC_NUM-1:0]          dl_in_vec;
    logic                         path_vld;
    logic [ID_WIDTH-1:0]          path_id;
    logic                         dl_detect_out;
    logic [PROC_NUM-1:0]          origin;
    logic                         token_clear;
    logic                         report_vld;
    logic                         report_ack;
    logic [ID_WIDTH+3:0]          report_len;
    logic [MAX_PATH*ID_WIDTH-1:0] report_path;
    logic                         report_closed;
    logic                         report_overflow;
    logic                         report_timeout;
    logic [7:0]                   deadlock_count;

    modport master (
        output dl_in_vec, path_vld, path_id, report_ack,
        input  dl_detect_out, origin, token_clear, report_vld, report_len, report_path,
        input  report_closed, report_overflow, report_timeout, deadlock_count
    );

    modport slave (
        input  dl_in_vec, path_vld, path_id, report_ack,
        output dl_detect_out, origin, token_clear, report_vld, report_len, report_path,
        output report_closed, report_overflow, report_timeout, deadlock_count
    );
endinterface

// File: rtl/deadlock_report_sequencer.sv
// Confirms persistent deadlock flags, freezes the detectors, records the token's
// dependency path and holds a report record until acknowledged.
module deadlock_report_sequencer #(
    parameter int unsigned PROC_NUM       = 3,
    parameter int unsigned ID_WIDTH       = 2,
    parameter int unsigned CONFIRM_CYCLES = 4,
    parameter int unsigned MAX_PATH       = 8,
    parameter int unsigned TRACE_TIMEOUT  = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    deadlock_report_sequencer_if.slave    bus
);

    localparam int unsigned LenW = ID_WIDTH + 4;
    localparam int unsigned IdxW = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;
    localparam int unsigned CnfW = $clog2(CONFIRM_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(TRACE_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StConfirm, StTrace, StReport, StClear} state_e;

    state_e                            state_q, state_d;
    logic [CnfW-1:0]                   cnf_q, cnf_d;
    logic [TmoW-1:0]                   tmo_q, tmo_d;
    logic [LenW-1:0]                   len_q, len_d;
    logic [MAX_PATH-1:0][ID_WIDTH-1:0] path_q, path_d;
    logic [PROC_NUM-1:0]               origin_q, origin_d;
    logic [ID_WIDTH-1:0]               origin_idx_q, origin_idx_d;
    logic                              closed_q, closed_d;
    logic                              overflow_q, overflow_d;
    logic                              timeout_q, timeout_d;
    logic [7:0]                        count_q, count_d;

    logic                              dl_any;
    logic                              found;
    logic [ID_WIDTH-1:0]               low_idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnf_q        <= '0;
            tmo_q        <= '0;
            len_q        <= '0;
            path_q       <= '0;
            origin_q     <= '0;
            origin_idx_q <= '0;
            closed_q     <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnf_q        <= cnf_d;
            tmo_q        <= tmo_d;
            len_q        <= len_d;
            path_q       <= path_d;
            origin_q     <= origin_d;
            origin_idx_q <= origin_idx_d;
            closed_q     <= closed_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    // Lowest-index asserted flag picks the origin process.
    always_comb begin
        found   = 1'b0;
        low_idx = '0;
        for (int unsigned i = 0; i < PROC_NUM; i++) begin
            if (bus.dl_in_vec[i] && !found) begin
                found   = 1'b1;
                low_idx = ID_WIDTH'(i);
            end
        end
    end

    assign dl_any = |bus.dl_in_vec;

    always_comb begin
        state_d      = state_q;
        cnf_d        = cnf_q;
        tmo_d        = tmo_q;
        len_d        = len_q;
        path_d       = path_q;
        origin_d     = origin_q;
        origin_idx_d = origin_idx_q;
        closed_d     = closed_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        count_d      = count_q;

        case (state_q)
            StIdle: begin
                if (dl_any) begin
                    if (CONFIRM_CYCLES <= 1) begin
                        origin_d     = PROC_NUM'(1) << low_idx;
                        origin_idx_d = low_idx;
                        state_d      = StTrace;
                    end else begin
                        cnf_d   = CnfW'(1);
                        state_d = StConfirm;
                    end
                end
            end
            StConfirm: begin
                if (!dl_any) begin
                    cnf_d   = '0;
                    state_d = StIdle;
                end else if (cnf_q == CnfW'(CONFIRM_CYCLES - 1)) begin
                    cnf_d        = '0;
                    origin_d     = PROC_NUM'(1) << low_idx;
                    origin_idx_d = low_idx;
                    state_d      = StTrace;
                end else begin
                    cnf_d = cnf_q + CnfW'(1);
                end
            end
            StTrace: begin
                tmo_d = tmo_q + TmoW'(1);
                if (bus.path_vld) begin
                    path_d[len_q[IdxW-1:0]] = bus.path_id;
                    len_d                   = len_q + LenW'(1);
                    if (bus.path_id == origin_idx_q) begin
                        closed_d = 1'b1;
                        state_d  = StReport;
                    end else if (len_q == LenW'(MAX_PATH - 1)) begin
                        overflow_d = 1'b1;
                        state_d    = StReport;
                    end
                end
                // Timeout only wins when neither closure nor overflow fired.
                if (state_d == StTrace && tmo_q == TmoW'(TRACE_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StReport;
                end
            end
            StReport: begin
                if (bus.report_ack) begin
                    cnf_d        = '0;
                    tmo_d        = '0;
                    len_d        = '0;
                    path_d       = '0;
                    origin_d     = '0;
                    origin_idx_d = '0;
                    closed_d     = 1'b0;
                    overflow_d   = 1'b0;
                    timeout_d    = 1'b0;
                    count_d      = (count_q == 8'hff) ? count_q : count_q + 8'd1;
                    state_d      = StClear;
                end
            end
            StClear: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.dl_detect_out   = (state_q == StTrace) || (state_q == StReport);
    assign bus.origin          = origin_q;
    assign bus.token_clear     = (state_q == StClear);
    assign bus.report_vld      = (state_q == StReport);
    assign bus.report_len      = len_q;
    assign bus.report_path     = path_q;
    assign bus.report_closed   = closed_q;
    assign bus.report_overflow = overflow_q;
    assign bus.report_timeout  = timeout_q;
    assign bus.deadlock_count  = count_q;

endmodule

// File: tb/tb_deadlock_report_sequencer.sv
// Directed bench for deadlock_report_sequencer: confirm filtering, closed,
// overflow and timeout reports, held report, idle ack and asynchronous reset.
module tb_deadlock_report_sequencer;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;

    deadlock_report_sequencer_if #(.PROC_NUM(3), .ID_WIDTH(2), .MAX_PATH(8)) bus ();

    deadlock_report_sequencer #(
        .PROC_NUM(3), .ID_WIDTH(2), .CONFIRM_CYCLES(4), .MAX_PATH(8), .TRACE_TIMEOUT(64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.dl_in_vec = '0; bus.path_vld = 1'b0; bus.path_id = '0; bus.report_ack = 1'b0;
        tick(); tick();
        n_vec++; if (bus.dl_detect_out !== 1'b0) begin n_err++; $display("FAIL reset_dl_detect got %b want 0", bus.dl_detect_out); end
        n_vec++; if (bus.origin !== 3'b000) begin n_err++; $display("FAIL reset_origin got %b want 000", bus.origin); end
        n_vec++; if (bus.token_clear !== 1'b0) begin n_err++; $display("FAIL reset_token_clear got %b want 0", bus.token_clear); end
        n_vec++; if (bus.report_vld !== 1'b0) begin n_err++; $display("FAIL reset_report_vld got %b want 0", bus.report_vld); end
        n_vec++; if (bus.report_path !== 16'h0000) begin n_err++; $display("FAIL reset_path got %h want 0000", bus.report_path); end
        n_vec++; if (bus.deadlock_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.deadlock_count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_transient();
        for (int r = 0; r < 2; r++) begin
            bus.dl_in_vec = 3'b010;
            for (int i = 0; i < 3; i++) begin
                tick();
                n_vec++; if (bus.dl_detect_out !== 1'b0) begin n_err++; $display("FAIL transient_dl_detect got %b want 0", bus.dl_detect_out); end
            end
            bus.dl_in_vec = 3'b000;
            tick(); tick();
            n_vec++; if (bus.dl_detect_out !== 1'b0) begin n_err++; $display("FAIL transient_idle_dl_detect got %b want 0", bus.dl_detect_out); end
        end
        n_vec++; if (bus.deadlock_count !== 8'd0) begin n_err++; $display("FAIL transient_count got %0d want 0", bus.deadlock_count); end
    endtask

    task automatic test_closed();
        bus.dl_in_vec = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.dl_detect_out !== 1'b0) begin n_err++; $display("FAIL closed_early_detect cyc %0d got %b want 0", i + 1, bus.dl_detect_out); end
        end
        tick();
        n_vec++; if (bus.dl_detect_out !== 1'b1) begin n_err++; $display("FAIL closed_detect_cyc4 got %b want 1", bus.dl_detect_out); end
        n_vec++; if (bus.origin !== 3'b010) begin n_err++; $display("FAIL closed_origin got %b want 010", bus.origin); end
        bus.dl_in_vec = 3'b000;
        bus.path_vld = 1'b1; bus.path_id = 2'd2; tick();
        bus.path_id = 2'd2; tick();
        n_vec++; if (bus.report_vld !== 1'b0) begin n_err++; $display("FAIL closed_vld_early got %b want 0", bus.report_vld); end
        bus.path_id = 2'd1; tick();
        bus.path_vld = 1'b0;
        n_vec++; if (bus.report_vld !== 1'b1) begin n_err++; $display("FAIL closed_vld got %b want 1", bus.report_vld); end
        n_vec++; if (bus.report_len !== 6'd3) begin n_err++; $display("FAIL closed_len got %0d want 3", bus.report_len); end
        n_vec++; if (bus.report_path !== 16'h001a) begin n_err++; $display("FAIL closed_path got %h want 001a", bus.report_path); end
        n_vec++; if ({bus.report_closed, bus.report_overflow, bus.report_timeout} !== 3'b100) begin
            n_err++; $display("FAIL closed_flags got %b want 100", {bus.report_closed, bus.report_overflow, bus.report_timeout}); end
        bus.report_ack = 1'b1; tick(); bus.report_ack = 1'b0;
        n_vec++; if (bus.token_clear !== 1'b1) begin n_err++; $display("FAIL closed_token_clear got %b want 1", bus.token_clear); end
        n_vec++; if ({bus.report_vld, bus.dl_detect_out} !== 2'b00) begin n_err++; $display("FAIL clear_vld_detect got %b want 00", {bus.report_vld, bus.dl_detect_out}); end
        n_vec++; if (bus.origin !== 3'b000) begin n_err++; $display("FAIL clear_origin got %b want 000", bus.origin); end
        n_vec++; if (bus.report_len !== 6'd0) begin n_err++; $display("FAIL clear_len got %0d want 0", bus.report_len); end
        tick();
        n_vec++; if (bus.token_clear !== 1'b0) begin n_err++; $display("FAIL clear_pulse_width got %b want 0", bus.token_clear); end
        n_vec++; if (bus.deadlock_count !== 8'd1) begin n_err++; $display("FAIL closed_count got %0d want 1", bus.deadlock_count); end
    endtask

    task automatic test_overflow();
        bus.dl_in_vec = 3'b001;
        repeat (4) tick();
        n_vec++; if (bus.origin !== 3'b001) begin n_err++; $display("FAIL ovf_origin got %b want 001", bus.origin); end
        bus.dl_in_vec = 3'b000;
        bus.path_vld = 1'b1; bus.path_id = 2'd2;
        repeat (7) tick();
        n_vec++; if (bus.report_vld !== 1'b0) begin n_err++; $display("FAIL ovf_vld_early got %b want 0", bus.report_vld); end
        tick();
        bus.path_vld = 1'b0;
        n_vec++; if (bus.report_vld !== 1'b1) begin n_err++; $display("FAIL ovf_vld got %b want 1", bus.report_vld); end
        n_vec++; if (bus.report_len !== 6'd8) begin n_err++; $display("FAIL ovf_len got %0d want 8", bus.report_len); end
        n_vec++; if (bus.report_path !== 16'haaaa) begin n_err++; $display("FAIL ovf_path got %h want aaaa", bus.report_path); end
        n_vec++; if ({bus.report_closed, bus.report_overflow, bus.report_timeout} !== 3'b010) begin
            n_err++; $display("FAIL ovf_flags got %b want 010", {bus.report_closed, bus.report_overflow, bus.report_timeout}); end
        bus.report_ack = 1'b1; tick(); bus.report_ack = 1'b0; tick();
        n_vec++; if (bus.deadlock_count !== 8'd2) begin n_err++; $display("FAIL ovf_count got %0d want 2", bus.deadlock_count); end
    endtask

    task automatic test_timeout();
        bus.dl_in_vec = 3'b001;
        repeat (4) tick();
        bus.dl_in_vec = 3'b000;
        repeat (63) tick();
        n_vec++; if (bus.report_vld !== 1'b0) begin n_err++; $display("FAIL tmo_vld_early got %b want 0", bus.report_vld); end
        n_vec++; if (bus.dl_detect_out !== 1'b1) begin n_err++; $display("FAIL tmo_detect got %b want 1", bus.dl_detect_out); end
        tick();
        n_vec++; if (bus.report_vld !== 1'b1) begin n_err++; $display("FAIL tmo_vld got %b want 1", bus.report_vld); end
        n_vec++; if (bus.report_len !== 6'd0) begin n_err++; $display("FAIL tmo_len got %0d want 0", bus.report_len); end
        n_vec++; if (bus.report_path !== 16'h0000) begin n_err++; $display("FAIL tmo_path got %h want 0000", bus.report_path); end
        n_vec++; if ({bus.report_closed, bus.report_overflow, bus.report_timeout} !== 3'b001) begin
            n_err++; $display("FAIL tmo_flags got %b want 001", {bus.report_closed, bus.report_overflow, bus.report_timeout}); end
        bus.report_ack = 1'b1; tick(); bus.report_ack = 1'b0; tick();
        n_vec++; if (bus.deadlock_count !== 8'd3) begin n_err++; $display("FAIL tmo_count got %0d want 3", bus.deadlock_count); end
    endtask

    task automatic test_held_report();
        bus.dl_in_vec = 3'b100;
        repeat (4) tick();
        n_vec++; if (bus.origin !== 3'b100) begin n_err++; $display("FAIL held_origin got %b want 100", bus.origin); end
        bus.dl_in_vec = 3'b000;
        bus.path_vld = 1'b1; bus.path_id = 2'd2; tick();
        bus.path_vld = 1'b0; bus.path_id = 2'd0;
        for (int c = 1; c <= 10; c++) begin
            n_vec++; if ({bus.report_vld, bus.dl_detect_out, bus.report_closed} !== 3'b111) begin
                n_err++; $display("FAIL held_ctrl cyc %0d got %b want 111", c, {bus.report_vld, bus.dl_detect_out, bus.report_closed}); end
            n_vec++; if ({bus.report_len, bus.report_path} !== {6'd1, 16'h0002}) begin
                n_err++; $display("FAIL held_data cyc %0d got %h want %h", c, {bus.report_len, bus.report_path}, {6'd1, 16'h0002}); end
            tick();
        end
        bus.report_ack = 1'b1;
        n_vec++; if (bus.report_vld !== 1'b1) begin n_err++; $display("FAIL held_vld_cyc11 got %b want 1", bus.report_vld); end
        tick(); bus.report_ack = 1'b0;
        n_vec++; if (bus.token_clear !== 1'b1) begin n_err++; $display("FAIL held_token_clear got %b want 1", bus.token_clear); end
        tick();
        n_vec++; if (bus.deadlock_count !== 8'd4) begin n_err++; $display("FAIL held_count got %0d want 4", bus.deadlock_count); end
    endtask

    task automatic test_idle_ack();
        bus.report_ack = 1'b1; tick();
        n_vec++; if (bus.token_clear !== 1'b0) begin n_err++; $display("FAIL idle_ack_token_clear got %b want 0", bus.token_clear); end
        tick(); bus.report_ack = 1'b0;
        n_vec++; if ({bus.report_vld, bus.dl_detect_out} !== 2'b00) begin n_err++; $display("FAIL idle_ack_vld got %b want 00", {bus.report_vld, bus.dl_detect_out}); end
        n_vec++; if (bus.deadlock_count !== 8'd4) begin n_err++; $display("FAIL idle_ack_count got %0d want 4", bus.deadlock_count); end
    endtask

    task automatic test_async_reset();
        bus.dl_in_vec = 3'b001;
        repeat (4) tick();
        bus.dl_in_vec = 3'b000;
        bus.path_vld = 1'b1;
        bus.path_id = 2'd2; tick();
        bus.path_id = 2'd3; tick();
        bus.path_id = 2'd2; tick();
        bus.path_vld = 1'b0;
        n_vec++; if (bus.report_len !== 6'd3) begin n_err++; $display("FAIL rst_pre_len got %0d want 3", bus.report_len); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({bus.dl_detect_out, bus.token_clear, bus.report_vld} !== 3'b000) begin
            n_err++; $display("FAIL rst_async_ctrl got %b want 000", {bus.dl_detect_out, bus.token_clear, bus.report_vld}); end
        n_vec++; if (bus.origin !== 3'b000) begin n_err++; $display("FAIL rst_async_origin got %b want 000", bus.origin); end
        n_vec++; if ({bus.report_len, bus.report_path} !== 22'd0) begin
            n_err++; $display("FAIL rst_async_data got %h want 0", {bus.report_len, bus.report_path}); end
        n_vec++; if (bus.deadlock_count !== 8'd0) begin n_err++; $display("FAIL rst_async_count got %0d want 0", bus.deadlock_count); end
        tick();
        n_vec++; if (bus.token_clear !== 1'b0) begin n_err++; $display("FAIL rst_token_clear got %b want 0", bus.token_clear); end
        reset = 1'b1;
        bus.dl_in_vec = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.dl_detect_out !== 1'b0) begin n_err++; $display("FAIL rst_reconfirm_early cyc %0d got %b want 0", i + 1, bus.dl_detect_out); end
        end
        tick();
        n_vec++; if (bus.dl_detect_out !== 1'b1) begin n_err++; $display("FAIL rst_reconfirm got %b want 1", bus.dl_detect_out); end
        bus.dl_in_vec = 3'b000;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_transient();
        test_closed();
        test_overflow();
        test_timeout();
        test_held_report();
        test_idle_ack();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
